// File: rtl/reg_status_commit.sv
// Architectural register file with per-register busy/tag rename status.
// Issue allocates a mapping; commit retires a value and releases a matching mapping.
module reg_status_commit #(
    parameter int NREG   = 32,
    parameter int REG_W  = 5,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_dest,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              commit_valid,
    input  logic [REG_W-1:0]  commit_addr,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_val,
    input  logic              flush,
    input  logic [REG_W-1:0]  rs_addr,
    output logic [DATA_W-1:0] rs_val,
    output logic              rs_busy,
    output logic [TAG_W-1:0]  rs_tag,
    input  logic [REG_W-1:0]  rt_addr,
    output logic [DATA_W-1:0] rt_val,
    output logic              rt_busy,
    output logic [TAG_W-1:0]  rt_tag,
    output logic [REG_W:0]    busy_count
);

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rd_t;

    logic [DATA_W-1:0] regfile [NREG];
    logic [TAG_W-1:0]  tags    [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              commit_clr;
    logic              commit_wr;
    logic              issue_set;
    rd_t               rd_a;
    rd_t               rd_b;

    function automatic logic [REG_W:0] popcount(input logic [NREG-1:0] v);
        logic [REG_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + (REG_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Commit releases only the mapping it created; a newer issue keeps the register busy.
    assign commit_wr  = commit_valid && (commit_addr != '0);
    assign commit_clr = commit_wr && busy[commit_addr] && (tags[commit_addr] == commit_tag);
    assign issue_set  = issue_valid && !flush && (issue_dest != '0);

    always_comb begin
        busy_nxt = busy;
        if (commit_clr) busy_nxt[commit_addr] = 1'b0;
        if (issue_set)  busy_nxt[issue_dest]  = 1'b1;
        if (flush)      busy_nxt              = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
                tags[i]    <= '0;
            end
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
            if (commit_wr) regfile[commit_addr] <= commit_val;
            if (issue_set) tags[issue_dest]     <= issue_tag;
        end
    end

    // Reads bypass a releasing commit but never see a same-cycle issue.
    function automatic rd_t read_port(input logic [REG_W-1:0] addr);
        rd_t r;
        r.busy = busy[addr];
        r.tag  = tags[addr];
        r.val  = regfile[addr];
        if (commit_clr && (addr == commit_addr)) begin
            r.busy = 1'b0;
            r.val  = commit_val;
        end
        return r;
    endfunction

    always_comb begin
        rd_a = read_port(rs_addr);
        rd_b = read_port(rt_addr);
    end

    assign rs_val  = rd_a.val;
    assign rs_busy = rd_a.busy;
    assign rs_tag  = rd_a.tag;
    assign rt_val  = rd_b.val;
    assign rt_busy = rd_b.busy;
    assign rt_tag  = rd_b.tag;

endmodule

// File: tb/tb_reg_status_commit.sv
// Scoreboard bench for reg_status_commit: stimulus pushes expected read results,
// a negedge monitor pops and compares them against both read ports and busy_count.
module tb_reg_status_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [4:0]  issue_tag;
    logic        commit_valid;
    logic [4:0]  commit_addr;
    logic [4:0]  commit_tag;
    logic [31:0] commit_val;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [31:0] rs_val;
    logic        rs_busy;
    logic [4:0]  rs_tag;
    logic [4:0]  rt_addr;
    logic [31:0] rt_val;
    logic        rt_busy;
    logic [4:0]  rt_tag;
    logic [5:0]  busy_count;

    reg_status_commit #(.NREG(32), .REG_W(5), .TAG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_tag(issue_tag),
        .commit_valid(commit_valid), .commit_addr(commit_addr),
        .commit_tag(commit_tag), .commit_val(commit_val),
        .flush(flush),
        .rs_addr(rs_addr), .rs_val(rs_val), .rs_busy(rs_busy), .rs_tag(rs_tag),
        .rt_addr(rt_addr), .rt_val(rt_val), .rt_busy(rt_busy), .rt_tag(rt_tag),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] av; logic ab; logic [4:0] at; bit atc;
        logic [31:0] bv; logic bb; logic [4:0] bt; bit btc;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read ports are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".rs_val"},  rs_val,  e.av);
            cmp({e.name, ".rs_busy"}, 32'(rs_busy), 32'(e.ab));
            if (e.atc) cmp({e.name, ".rs_tag"}, 32'(rs_tag), 32'(e.at));
            cmp({e.name, ".rt_val"},  rt_val,  e.bv);
            cmp({e.name, ".rt_busy"}, 32'(rt_busy), 32'(e.bb));
            if (e.btc) cmp({e.name, ".rt_tag"}, 32'(rt_tag), 32'(e.bt));
            cmp({e.name, ".busy_count"}, 32'(busy_count), 32'(e.cnt));
        end
    end

    task automatic expect2(input string n,
                           input logic [31:0] av, input logic ab, input logic [4:0] at, input bit atc,
                           input logic [31:0] bv, input logic bb, input logic [4:0] bt, input bit btc,
                           input logic [5:0] cnt);
        exp_t e;
        e.name = n;
        e.av = av; e.ab = ab; e.at = at; e.atc = atc;
        e.bv = bv; e.bb = bb; e.bt = bt; e.btc = btc;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Both ports on the same address, same expectation.
    task automatic expect1(input string n, input logic [4:0] a, input logic [31:0] v,
                           input logic b, input logic [4:0] t, input bit tc, input logic [5:0] cnt);
        rs_addr = a;
        rt_addr = a;
        expect2(n, v, b, t, tc, v, b, t, tc, cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] d, input logic [4:0] t);
        issue_valid = 1'b1; issue_dest = d; issue_tag = t;
    endtask

    task automatic do_commit(input logic [4:0] a, input logic [4:0] t, input logic [31:0] v);
        commit_valid = 1'b1; commit_addr = a; commit_tag = t; commit_val = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_dest = '0; issue_tag = '0;
        commit_valid = 1'b0; commit_addr = '0; commit_tag = '0; commit_val = '0;
        flush = 1'b0; rs_addr = '0; rt_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: every register clear on both ports.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            expect2($sformatf("reset_r%0d", i), 0, 0, 0, 1, 0, 0, 0, 1, 0);
            tick();
        end

        // Issue r5/tag3; same-cycle read still sees old mapping.
        do_issue(5, 3);
        expect1("issue_r5_same", 5, 0, 0, 0, 1, 0);
        tick();
        expect1("r5_busy", 5, 0, 1, 3, 1, 1);
        tick();
        do_commit(5, 3, 32'hDEADBEEF);
        rs_addr = 0; rt_addr = 0;
        expect2("commit_r5_cycle", 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tick();
        expect1("r5_committed", 5, 32'hDEADBEEF, 0, 0, 0, 0);
        tick();

        // Stale commit must not release a newer mapping.
        do_issue(7, 1);
        tick();
        do_issue(7, 4);
        expect1("r7_tag1", 7, 0, 1, 1, 1, 1);
        tick();
        do_commit(7, 1, 32'h11);
        expect1("r7_stale_commit", 7, 0, 1, 4, 1, 1);
        tick();
        do_commit(7, 4, 32'h22);
        expect1("r7_bypass_22", 7, 32'h22, 0, 0, 0, 1);
        tick();
        // Regfile retained 0x11 from the stale commit before the bypass cycle.
        expect1("r7_final", 7, 32'h22, 0, 0, 0, 0);
        tick();

        // Issue and commit to the same register in one cycle: issue wins.
        do_issue(9, 2);
        tick();
        expect1("r9_tag2", 9, 0, 1, 2, 1, 1);
        tick();
        do_issue(9, 6);
        do_commit(9, 2, 32'h99);
        rs_addr = 0; rt_addr = 0;
        expect2("r9_collide_cycle", 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tick();
        expect1("r9_issue_wins", 9, 32'h99, 1, 6, 1, 1);
        tick();

        // Commit bypass to read ports in the same cycle.
        do_issue(3, 0);
        tick();
        do_commit(3, 0, 32'h55);
        expect1("r3_bypass", 3, 32'h55, 0, 0, 0, 2);
        tick();
        expect1("r3_after", 3, 32'h55, 0, 0, 0, 1);
        tick();

        // Flush drops every mapping, ignores issue, still writes the regfile.
        do_issue(1, 7);
        tick();
        do_issue(2, 8);
        tick();
        do_issue(3, 9);
        tick();
        rs_addr = 1; rt_addr = 2;
        expect2("pre_flush", 0, 1, 7, 1, 0, 1, 8, 1, 4);
        flush = 1'b1;
        do_issue(4, 10);
        do_commit(6, 0, 32'h66);
        tick();
        rs_addr = 1; rt_addr = 4;
        expect2("post_flush_r1_r4", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rs_addr = 6; rt_addr = 9;
        expect2("post_flush_r6_r9", 32'h66, 0, 0, 0, 32'h99, 0, 0, 0, 0);
        tick();

        // r0 ignores issue and commit.
        do_issue(0, 5);
        do_commit(0, 5, 32'hFFFF_FFFF);
        expect1("r0_same_cycle", 0, 0, 0, 0, 1, 0);
        tick();
        expect1("r0_after", 0, 0, 0, 0, 1, 0);
        tick();

        // Highest register address.
        do_issue(31, 31);
        tick();
        expect1("r31_busy", 31, 0, 1, 31, 1, 1);
        tick();

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
